whack_response_judge: RTL

WHACK_RESPONSE_JUDGE -- requirements
Module: whack_response_judge

---
 rtl/whack_response_judge.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/whack_response_judge.sv
// ---------------------------------------------------------------------------
// whack_response_judge: whack-a-mole reaction judge (score, lives, game over)
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module whack_response_judge #(
  parameter int WIN_W     = 27,
  parameter int SCORE_W   = 8,
  parameter int MAX_LIVES = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mole_valid,
  input  logic [1:0]         mole_pos,
  input  logic [WIN_W-1:0]   window_load,
  input  logic [3:0]         key_n,
  output logic               ready,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               game_over
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_RESULT = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  localparam logic [1:0]         LIVES_INIT = 2'(MAX_LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

  state_t             state_q, state_d;
  logic [3:0]         sync1_q, sync1_d;
  logic [3:0]         sync2_q, sync2_d;
  logic [3:0]         dly_q, dly_d;
  logic [1:0]         pos_q, pos_d;
  logic [WIN_W-1:0]   timer_q, timer_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         lives_q, lives_d;

  logic [3:0]         press_evt;
  logic [3:0]         pos_onehot;

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
  end

  // Falling edge of the synchronized active-low key: held keys fire once.
  assign press_evt  = ~sync2_q & dly_q;
  assign pos_onehot = 4'b0001 << pos_q;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    timer_d = timer_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    score_d = score_q;
    lives_d = lives_q;

    case (state_q)
      S_IDLE: begin
        if (mole_valid) begin
          pos_d   = mole_pos;
          timer_d = window_load;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        // A press on the final timer cycle still wins over the timeout.
        if (|press_evt) begin
          state_d = S_RESULT;
          if (press_evt == pos_onehot) begin
            hit_d = 1'b1;
          end else begin
            miss_d = 1'b1;
          end
        end else if (timer_q == '0) begin
          state_d = S_RESULT;
          miss_d  = 1'b1;
        end else begin
          timer_d = timer_q - WIN_W'(1);
        end
        if (hit_d && (score_q != SCORE_MAX)) begin
          score_d = score_q + SCORE_W'(1);
        end
        if (miss_d) begin
          lives_d = lives_q - 2'd1;
        end
      end
      S_RESULT: begin
        state_d = (lives_q == 2'd0) ? S_OVER : S_IDLE;
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      dly_q   <= 4'hF;
      pos_q   <= 2'd0;
      timer_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      score_q <= '0;
      lives_q <= LIVES_INIT;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
      pos_q   <= pos_d;
      timer_q <= timer_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      score_q <= score_d;
      lives_q <= lives_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign game_over = (state_q == S_OVER);
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign lives     = lives_q;

endmodule

`default_nettype wire
